// File: rtl/demux_pkg.sv
// Shared constants and types for the demux deserializer slice.
package demux_pkg;
   localparam int NCH   = 4;
   localparam int SEL_W = 2;
   localparam int W_DEF = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ostate_t;
endpackage

// File: rtl/demux_deser_if.sv
// Serial-in / word-out bus between the upstream 1-to-4 demux and the deserializer.
interface demux_deser_if
   import demux_pkg::*;
#(
   parameter int W = W_DEF
);
   logic [SEL_W-1:0] s;
   logic [NCH-1:0]   y;
   logic             bit_vld;
   logic             out_rdy;
   logic             clr;
   logic             out_vld;
   logic [SEL_W-1:0] out_ch;
   logic [W-1:0]     out_data;
   logic [NCH-1:0]   ovf;
   logic             err;

   modport master (
      output s, y, bit_vld, out_rdy, clr,
      input  out_vld, out_ch, out_data, ovf, err
   );

   modport slave (
      input  s, y, bit_vld, out_rdy, clr,
      output out_vld, out_ch, out_data, ovf, err
   );
endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter: the channel after the last grant has top priority.
module rr_arb4
   import demux_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   req,
   input  logic             upd,
   output logic [SEL_W-1:0] gnt,
   output logic             gnt_vld
);
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] idx;

   // Scan from ptr upwards (wrapping); descending loop lets the nearest requester win.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = ptr + SEL_W'(i);
         if (req[idx]) begin
            gnt     = idx;
            gnt_vld = 1'b1;
         end
      end
   end

   // Advance the priority pointer past the channel just granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (upd && gnt_vld) begin
         ptr <= gnt + SEL_W'(1);
      end
   end
endmodule

// File: rtl/demux_deser.sv
// Per-channel serial-to-parallel assembly behind a 1-to-4 demux, with a
// one-word hold per channel and a round-robin arbitrated output register.
module demux_deser
   import demux_pkg::*;
#(
   parameter int W = W_DEF
)(
   input  logic clk,
   input  logic rst_n,
   demux_deser_if.slave bus
);
   localparam int CW = $clog2(W);

   logic [W-1:0]     sr   [NCH];
   logic [CW-1:0]    cnt  [NCH];
   logic [W-1:0]     hold [NCH];
   logic [NCH-1:0]   hold_full;
   ostate_t          state;
   logic [SEL_W-1:0] out_ch;
   logic [W-1:0]     out_data;
   logic [NCH-1:0]   ovf;
   logic             err;

   logic [NCH-1:0]   sel_oh;
   logic [NCH-1:0]   drain_oh;
   logic [NCH-1:0]   ovf_set;
   logic             bit_in;
   logic             stray;
   logic             word_done;
   logic [W-1:0]     new_word;
   logic             load;
   logic [SEL_W-1:0] gnt;
   logic             gnt_vld;

   // Decode the current bit, the completed word and which hold gets drained this edge.
   always_comb begin
      sel_oh            = '0;
      sel_oh[bus.s]     = 1'b1;
      bit_in            = bus.y[bus.s];
      stray             = bus.bit_vld && (|(bus.y & ~sel_oh));
      word_done         = bus.bit_vld && (cnt[bus.s] == CW'(W - 1));
      new_word          = {sr[bus.s][W-2:0], bit_in};
      load              = (state == EMPTY) || bus.out_rdy;
      drain_oh          = '0;
      if (load && gnt_vld) drain_oh[gnt] = 1'b1;
      ovf_set           = '0;
      if (word_done && hold_full[bus.s] && !drain_oh[bus.s]) ovf_set = sel_oh;
   end

   rr_arb4 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (hold_full),
      .upd     (load),
      .gnt     (gnt),
      .gnt_vld (gnt_vld)
   );

   // Shift the selected channel's bit in; a completed word moves to hold unless hold stays occupied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            sr[c]   <= '0;
            cnt[c]  <= '0;
            hold[c] <= '0;
         end
         hold_full <= '0;
      end else begin
         hold_full <= hold_full & ~drain_oh;
         if (bus.bit_vld) begin
            sr[bus.s] <= new_word;
            if (word_done) begin
               cnt[bus.s] <= '0;
               if (!hold_full[bus.s] || drain_oh[bus.s]) begin
                  hold[bus.s]      <= new_word;
                  hold_full[bus.s] <= 1'b1;
               end
            end else begin
               cnt[bus.s] <= cnt[bus.s] + CW'(1);
            end
         end
      end
   end

   // Sticky flags: clear first, so a set on the same edge still lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= '0;
         err <= 1'b0;
      end else begin
         ovf <= (bus.clr ? '0 : ovf) | ovf_set;
         err <= (bus.clr ? 1'b0 : err) | stray;
      end
   end

   // Output FSM: reload whenever empty or the current word is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_ch   <= '0;
         out_data <= '0;
      end else if (load) begin
         if (gnt_vld) begin
            state    <= FULL;
            out_ch   <= gnt;
            out_data <= hold[gnt];
         end else begin
            state    <= EMPTY;
         end
      end
   end

   assign bus.out_vld  = (state == FULL);
   assign bus.out_ch   = out_ch;
   assign bus.out_data = out_data;
   assign bus.ovf      = ovf;
   assign bus.err      = err;
endmodule

// File: doc/demux_deser.md
DEMUX_DESER -- requirements
Module: demux_deser

Interface
REQ-001 Parameter: W, 8, word width in bits per channel (W >= 2).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: s  input  2  channel select currently driving the 1-to-4 demux upstream.
REQ-005 Port: y  input  4  demux outputs; only y[s] may carry data, others 0.
REQ-006 Port: bit_vld  input  1  y[s] holds a valid serial bit this cycle.
REQ-007 Port: out_rdy  input  1  downstream accepts the word this cycle.
REQ-008 Port: out_vld  output  1  out_ch/out_data valid.
REQ-009 Port: out_ch  output  2  channel index of the presented word.
REQ-010 Port: out_data  output  W  assembled word, first received bit in MSB.
REQ-011 Port: ovf  output  4  per-channel sticky overflow flags.
REQ-012 Port: err  output  1  sticky flag for a nonzero unselected demux output.
REQ-013 Port: clr  input  1  synchronous clear of ovf and err.

Function
REQ-014 On an edge with bit_vld=1, the block shall shift y[s] into shift register sr[s] (sr <= {sr[W-2:0], y[s]}) and increment bit counter cnt[s].
REQ-015 On the edge where cnt[s] reaches W-1, the block shall move the complete word into hold[s], set hold_full[s], and reset cnt[s] to 0.
REQ-016 Channels not selected, or with bit_vld=0, shall keep sr and cnt unchanged; partial words shall persist across select changes.
REQ-017 On any edge with bit_vld=1 and y[j]=1 for some j != s, the block shall set err; the bit for channel s shall still be captured.
REQ-018 The output stage shall be a 2-state FSM: EMPTY (out_vld=0) and FULL (out_vld=1).
REQ-019 In EMPTY, or in FULL when out_rdy=1, the block shall load the output register from the round-robin winner among hold_full channels, clear that hold_full, and set out_vld; if no hold is full, it shall go to EMPTY.
REQ-020 In FULL with out_rdy=0, out_vld, out_ch and out_data shall remain stable.
REQ-021 Round-robin priority shall start at the channel after the last granted channel, wrapping 3 -> 0.
REQ-022 Latency: if the last bit is sampled at edge k and the output is free with no competing channel, out_vld shall be 1 after edge k+1.
REQ-023 If a word completes for channel c while hold_full[c]=1 and hold[c] is not drained that edge, the new word shall be dropped, hold[c] kept, ovf[c] set, and cnt[c] reset to 0.
REQ-024 If hold[c] is drained on the same edge a new word for c completes, the new word shall be stored with no overflow.
REQ-025 clr=1 shall zero ovf and err; a set event on the same edge shall take priority.
REQ-026 out_vld shall never be 1 when no word has been accepted since reset.

Reset
REQ-027 When rst_n=0, the block shall asynchronously zero sr, cnt, hold, hold_full, out_vld, out_ch, out_data, ovf and err, and set the round-robin pointer so channel 0 has highest priority.
REQ-028 A reset asserted mid-word or mid-handshake shall discard all partial and pending words; operation shall resume on the first edge after rst_n deasserts.

Structure
REQ-029 A shared package demux_pkg shall hold NCH=4, SEL_W=2, the output FSM state enum (EMPTY, FULL) and the default W.
REQ-030 Round-robin selection shall be one sub-module, rr_arb4 (4-bit request, 2-bit grant index, pointer update on grant).

Verification
REQ-031 Single-word test: W=8, s=2, send 0xA5 MSB-first with bit_vld every cycle and out_rdy=1 -> out_vld one edge after the last bit, out_ch=2, out_data=0xA5.
REQ-032 Interleave test: alternate bits of 0x3C on ch0 and 0xC3 on ch1 each cycle -> ch0 word 0x3C, then ch1 word 0xC3, each once, with no ovf.
REQ-033 Arbitration test: hold out_rdy=0 and complete words on ch0, ch1 and ch3, then assert out_rdy -> output order ch0, ch1, ch3, then a new ch0 word is granted after ch3.
REQ-034 Overflow test: out_rdy=0, output FULL, hold[1] full, complete another ch1 word -> ovf=4'b0010, original hold[1] delivered later; clr -> ovf=0.
REQ-035 Error and reset test: y=4'b1001 with s=0 and bit_vld=1 -> err=1; then rst_n=0 mid-word -> all outputs 0, and a fresh full word afterwards is assembled correctly.
